macrocell: RTL

//   Downstream consumer of the per-macrocell product terms (5 ANDed PT outputs).
//   ORs the PTs routed to the sum, plus optional cascade, and applies XOR polarity.

---
 rtl/macrocell_pkg.sv | 23 ++
 rtl/macrocell_if.sv | 30 +++
 rtl/macrocell_regcore.sv | 57 +++++
 rtl/macrocell.sv | 74 +++++++
 4 files changed

// File: rtl/macrocell_pkg.sv
// Shared encodings for the macrocell: register modes, clock selects, PT roles.
package macrocell_pkg;

  typedef enum logic [1:0] {
    FF_COMB  = 2'b00,
    FF_D     = 2'b01,
    FF_T     = 2'b10,
    FF_LATCH = 2'b11
  } ff_mode_e;

  typedef enum logic [1:0] {
    CLK_GCLK0 = 2'b00,
    CLK_GCLK1 = 2'b01,
    CLK_GCLK2 = 2'b10,
    CLK_PT3   = 2'b11
  } clk_sel_e;

  localparam int PT_AR  = 1;
  localparam int PT_OE  = 2;
  localparam int PT_CLK = 3;
  localparam int PT_AP  = 4;

endpackage

// File: rtl/macrocell_if.sv
// Product-term, clock, configuration and output bundle of one macrocell.
interface macrocell_if;
  logic [4:0] pt;
  logic [2:0] gclk;
  logic       cascade_in;
  logic [4:0] cfg_pt_special;
  logic       cfg_cascade_in;
  logic       cfg_cascade_out;
  logic       cfg_xor_inv;
  logic [1:0] cfg_ff_mode;
  logic [1:0] cfg_clk_sel;
  logic       cfg_oe_const;
  logic       cfg_flb_comb;
  logic       q;
  logic       oe;
  logic       mc_flb;
  logic       cascade_out;

  modport master (
    output pt, gclk, cascade_in, cfg_pt_special, cfg_cascade_in, cfg_cascade_out,
           cfg_xor_inv, cfg_ff_mode, cfg_clk_sel, cfg_oe_const, cfg_flb_comb,
    input  q, oe, mc_flb, cascade_out
  );

  modport slave (
    input  pt, gclk, cascade_in, cfg_pt_special, cfg_cascade_in, cfg_cascade_out,
           cfg_xor_inv, cfg_ff_mode, cfg_clk_sel, cfg_oe_const, cfg_flb_comb,
    output q, oe, mc_flb, cascade_out
  );
endinterface

// File: rtl/macrocell_regcore.sv
// Macrocell storage element: clock-source edge detector plus prioritised
// AR/AP and D/T/latch update. Device clocks are sampled levels; an edge is
// seen on the first tick where the source is high and its history bit is low.
module mc_regcore
  import macrocell_pkg::*;
#(
  parameter logic Q_INIT        = 1'b0,
  parameter logic SRC_PREV_INIT = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     src_i,
  input  logic     ce_i,
  input  logic     d_i,
  input  logic     ar_i,
  input  logic     ap_i,
  input  ff_mode_e mode_i,
  output logic     q_o
);

  logic q_q, q_d;
  logic src_prev_q;
  logic edge_det;

  assign edge_det = src_i & ~src_prev_q;

  // Next register value: AR beats AP, both beat any clocked update.
  always_comb begin
    q_d = q_q;
    if (ar_i) begin
      q_d = 1'b0;
    end else if (ap_i) begin
      q_d = 1'b1;
    end else begin
      case (mode_i)
        FF_D:     if (edge_det & ce_i) q_d = d_i;
        FF_T:     if (edge_det & ce_i) q_d = q_q ^ d_i;
        FF_LATCH: if (src_i & ce_i)    q_d = d_i;
        default:  q_d = q_q;
      endcase
    end
  end

  // Register and clock history; SRC_PREV_INIT=1 suppresses a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= Q_INIT;
      src_prev_q <= SRC_PREV_INIT;
    end else begin
      q_q        <= q_d;
      src_prev_q <= src_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/macrocell.sv
// Macrocell top: sum-of-products OR with cascade, XOR polarity, clock/CE
// selection, OE and feedback muxing around the mc_regcore storage element.
module macrocell
  import macrocell_pkg::*;
#(
  parameter logic Q_INIT        = 1'b0,
  parameter logic SRC_PREV_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  macrocell_if.slave  bus
);

  logic [4:0] sum_en;
  logic       raw_sum;
  logic       local_sum;
  logic       d;
  logic       src;
  logic       ce;
  logic       ar;
  logic       ap;
  logic       q_reg;
  ff_mode_e   mode;
  clk_sel_e   clk_sel;

  assign mode    = ff_mode_e'(bus.cfg_ff_mode);
  assign clk_sel = clk_sel_e'(bus.cfg_clk_sel);

  // Sum term: PT0 always participates; a special PT is pulled out of the OR.
  always_comb begin
    sum_en    = ~bus.cfg_pt_special;
    sum_en[0] = 1'b1;
    raw_sum   = (|(bus.pt & sum_en)) | (bus.cfg_cascade_in & bus.cascade_in);
  end

  assign bus.cascade_out = bus.cfg_cascade_out ? raw_sum : 1'b0;
  assign local_sum       = bus.cfg_cascade_out ? 1'b0 : raw_sum;
  assign d               = local_sum ^ bus.cfg_xor_inv;

  // Clock source select; PT3 becomes the clock only in the PT3 select.
  always_comb begin
    case (clk_sel)
      CLK_GCLK0: src = bus.gclk[0];
      CLK_GCLK1: src = bus.gclk[1];
      CLK_GCLK2: src = bus.gclk[2];
      default:   src = bus.pt[PT_CLK];
    endcase
  end

  // PT3 acts as clock enable only while it is not the clock itself.
  assign ce = (bus.cfg_pt_special[PT_CLK] && (clk_sel != CLK_PT3)) ? bus.pt[PT_CLK] : 1'b1;
  assign ar = bus.cfg_pt_special[PT_AR] & bus.pt[PT_AR];
  assign ap = bus.cfg_pt_special[PT_AP] & bus.pt[PT_AP];

  mc_regcore #(
    .Q_INIT        (Q_INIT),
    .SRC_PREV_INIT (SRC_PREV_INIT)
  ) u_regcore (
    .clk    (clk),
    .rst_n  (rst_n),
    .src_i  (src),
    .ce_i   (ce),
    .d_i    (d),
    .ar_i   (ar),
    .ap_i   (ap),
    .mode_i (mode),
    .q_o    (q_reg)
  );

  assign bus.q      = (mode == FF_COMB) ? d : q_reg;
  assign bus.oe     = bus.cfg_pt_special[PT_OE] ? bus.pt[PT_OE] : bus.cfg_oe_const;
  assign bus.mc_flb = bus.cfg_flb_comb ? d : bus.q;

endmodule
